// File: rtl/mem_1kb_sync_ram.sv
// Single-port 1024 x 8 synchronous RAM: en=1 writes, en=0 reads into a registered output.
// Optional per-word even parity with a parity_err flag when MEM_1KB_PARITY_EN is defined.
module mem_1kb_sync_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024   // must equal 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout
`ifdef MEM_1KB_PARITY_EN
  ,
  output logic              parity_err
`endif
);

`ifdef MEM_1KB_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int WORD_W = DATA_W + PAR_W;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] wr_word;

  // Parity bit, when present, rides in the MSB of each stored word.
  always_comb begin
`ifdef MEM_1KB_PARITY_EN
    wr_word = {^datain, datain};
`else
    wr_word = datain;
`endif
  end

  // NOTE: the array has no reset on purpose; clearing it would block RAM inference,
  // so reset only gates the write enable and contents survive a reset.
  always_ff @(posedge clk) begin
    if (rst && en) begin
      // NOTE: non-blocking assignments for all clocked state so every reader sees pre-edge values.
      mem[address] <= wr_word;
    end
  end

  // Read register: cleared by reset, loaded only on read cycles, held across writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dataout <= '0;
    end else if (!en) begin
      dataout <= mem[address][DATA_W-1:0];
    end
  end

`ifdef MEM_1KB_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      parity_err <= 1'b0;
    end else if (!en) begin
      parity_err <= (^mem[address][DATA_W-1:0]) != mem[address][DATA_W];
    end
  end
`endif

endmodule

// File: tb/tb_mem_1kb_sync_ram.sv
// Self-checking bench for mem_1kb_sync_ram: directed cases plus randomized traffic
// compared against an array-based reference model of the RAM.
module tb_mem_1kb_sync_ram;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] datain;
  logic [DATA_W-1:0] dataout;
`ifdef MEM_1KB_PARITY_EN
  logic              parity_err;
`endif

  mem_1kb_sync_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .address (address),
    .datain  (datain),
    .dataout (dataout)
`ifdef MEM_1KB_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: what the RAM holds, which words are known, and what dataout should be.
  logic [DATA_W-1:0] model_mem   [DEPTH];
  bit                model_valid [DEPTH];
  bit                model_bad   [DEPTH];
  logic [DATA_W-1:0] exp_dout;
  bit                exp_known;
  bit                exp_perr;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, advance model at posedge, compare just after.
  task automatic op(input string tag, input bit r, input bit e, input int a, input int d);
    @(negedge clk);
    rst     = r;
    en      = e;
    address = a[ADDR_W-1:0];
    datain  = d[DATA_W-1:0];
    @(posedge clk);
    if (!r) begin
      exp_dout  = '0;
      exp_known = 1'b1;
      exp_perr  = 1'b0;
    end else if (e) begin
      model_mem[a]   = d[DATA_W-1:0];
      model_valid[a] = 1'b1;
      model_bad[a]   = 1'b0;
    end else begin
      exp_dout  = model_mem[a];
      exp_known = model_valid[a];
      exp_perr  = model_bad[a];
    end
    #1;
    if (exp_known) begin
      check(tag, dataout, exp_dout);
`ifdef MEM_1KB_PARITY_EN
      check({tag, "_perr"}, parity_err, exp_perr);
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model_valid[i] = 1'b0;
      model_bad[i]   = 1'b0;
      model_mem[i]   = '0;
    end
    exp_known = 1'b0;
    exp_dout  = '0;
    exp_perr  = 1'b0;
    rst = 1'b0; en = 1'b0; address = '0; datain = '0;

    op("reset_init", 0, 0, 0, 0);
    op("reset_init2", 0, 0, 0, 0);

    // Reset must block writes: seed 800, then hammer it with en=1 under reset.
    op("seed_wr800", 1, 1, 800, 8'h07);
    for (int i = 0; i < 5; i++) op("rst_blocks_wr", 0, 1, 800, 50);
    op("rd800_kept", 1, 0, 800, 0);
    op("rst_clear", 0, 0, 0, 0);

    // Writes leave dataout alone, then read back in order.
    op("wr800_hold", 1, 1, 800, 50);
    op("wr900_hold", 1, 1, 900, 60);
    op("rd800", 1, 0, 800, 0);
    op("rd900", 1, 0, 900, 0);

    // Address extremes without aliasing.
    op("wr0", 1, 1, 0, 8'hA5);
    op("wr1023", 1, 1, 1023, 8'h5A);
    op("rd0", 1, 0, 0, 0);
    op("rd1023", 1, 0, 1023, 0);
    op("rd0_again", 1, 0, 0, 0);

    // Read right after write, reset dropping a read, then normal read.
    op("wr10", 1, 1, 10, 8'h33);
    op("rd10", 1, 0, 10, 0);
    op("rst_during_rd", 0, 0, 10, 0);
    op("rd10_after_rst", 1, 0, 10, 0);

    // Randomized mix; narrow address window on most ops to force read-after-write hits.
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit e;
      int a;
      r = ($urandom_range(0, 31) != 0);
      e = $urandom_range(0, 1);
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                      : int'($urandom_range(0, 15));
      op("rand", r, e, a, int'($urandom_range(0, 255)));
    end

`ifdef MEM_1KB_PARITY_EN
    // Corrupt one stored data bit behind the RAM's back; the next read of it must flag.
    op("par_wr", 1, 1, 77, 8'h96);
    op("par_rd_ok", 1, 0, 77, 0);
    @(negedge clk);
    dut.mem[77][0] = ~dut.mem[77][0];
    model_mem[77]  = model_mem[77] ^ 8'h01;
    model_bad[77]  = 1'b1;
    op("par_wr_other", 1, 1, 78, 8'h11);
    op("par_rd_bad", 1, 0, 77, 0);
    op("par_hold_wr", 1, 1, 79, 8'h22);
    op("par_rd_good", 1, 0, 78, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
